// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus: ROM address/data and the decoder-facing
// phase strobes, opcode/operand fields and jump-taken return.
interface fetch_sequencer_if #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 16
);
  logic [PC_WIDTH-1:0]    PC_out;
  logic [INSTR_WIDTH-1:0] Instr_in;
  logic                   T1;
  logic                   T2;
  logic                   T3;
  logic                   T4;
  logic [4:0]             opcode;
  logic [INSTR_WIDTH-6:0] Operand;
  logic                   PC_Update;

  modport master (
    output PC_out, T1, T2, T3, T4,
    output opcode, Operand,
    input  Instr_in, PC_Update
  );

  modport slave (
    input  PC_out, T1, T2, T3, T4,
    input  opcode, Operand,
    output Instr_in, PC_Update
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch and T1-T4 phase generator: PC, IR,
// retired-instruction counter and a one-hot sequencing FSM.
module fetch_sequencer #(
  parameter int         PC_WIDTH    = 8,
  parameter int         INSTR_WIDTH = 16,
  parameter logic [4:0] HALT_OPCODE = 5'b11111
) (
  input  logic                clk,
  input  logic                Reset,
  input  logic                Run,
  input  logic                Stall,
  fetch_sequencer_if.master   bus,
  output logic                Halted,
  output logic [15:0]         Instr_count
);

  localparam int B_IDLE  = 0;
  localparam int B_FETCH = 1;
  localparam int B_S1    = 2;
  localparam int B_S2    = 3;
  localparam int B_S3    = 4;
  localparam int B_S4    = 5;
  localparam int B_HALT  = 6;

  typedef enum logic [6:0] {
    IDLE  = 7'b0000001,
    FETCH = 7'b0000010,
    S1    = 7'b0000100,
    S2    = 7'b0001000,
    S3    = 7'b0010000,
    S4    = 7'b0100000,
    HALT  = 7'b1000000
  } state_t;

  state_t                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] ir_q, ir_d;
  logic [15:0]            cnt_q, cnt_d;
  logic                   fetch_halt;

  assign fetch_halt =
    bus.Instr_in[INSTR_WIDTH-1 -: 5] == HALT_OPCODE;

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    // Stall freezes everything, including the S4 PC update.
    if (!Stall) begin
      unique case (1'b1)
        state_q[B_IDLE]: begin
          if (Run) state_d = FETCH;
        end
        state_q[B_FETCH]: begin
          ir_d    = bus.Instr_in;
          state_d = fetch_halt ? HALT : S1;
        end
        state_q[B_S1]: state_d = S2;
        state_q[B_S2]: state_d = S3;
        state_q[B_S3]: state_d = S4;
        state_q[B_S4]: begin
          pc_d    = bus.PC_Update ? ir_q[PC_WIDTH-1:0]
                                  : pc_q + 1'b1;
          cnt_d   = cnt_q + 1'b1;
          state_d = Run ? FETCH : IDLE;
        end
        state_q[B_HALT]: state_d = HALT;
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.T1      = state_q[B_S1];
  assign bus.T2      = state_q[B_S2];
  assign bus.T3      = state_q[B_S3];
  assign bus.T4      = state_q[B_S4];
  assign bus.PC_out  = pc_q;
  assign bus.opcode  = ir_q[INSTR_WIDTH-1 -: 5];
  assign bus.Operand = ir_q[INSTR_WIDTH-6:0];
  assign Halted      = state_q[B_HALT];
  assign Instr_count = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed timing cases plus random
// programs checked by a scoreboard fed from a program-walk model.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Run = 1'b0;
  logic        Stall = 1'b0;
  logic        Halted;
  logic [15:0] Instr_count;
  logic [15:0] rom [256];
  logic        pcu_t2 = 1'b0;
  logic        sb_on = 1'b0;
  int          tests = 0;
  int          fails = 0;

  typedef struct {
    logic [7:0]  pc;
    logic [15:0] ir;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q [$];
  exp_t mon_e;
  logic prev_t1 = 1'b0;

  fetch_sequencer_if #(.PC_WIDTH(8), .INSTR_WIDTH(16)) bus ();

  fetch_sequencer #(
    .PC_WIDTH(8), .INSTR_WIDTH(16), .HALT_OPCODE(5'b11111)
  ) dut (
    .clk(clk), .Reset(Reset), .Run(Run), .Stall(Stall),
    .bus(bus), .Halted(Halted), .Instr_count(Instr_count)
  );

  always #5 clk = ~clk;

  // ROM and a minimal decoder: opcode 5 is a taken jump.
  assign bus.Instr_in  = rom[bus.PC_out];
  assign bus.PC_Update = (bus.opcode == 5'h05) &&
                         (pcu_t2 ? bus.T2 : bus.T4);

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: one expected entry per instruction at T1 onset.
  always @(negedge clk) begin
    if (!Reset) begin
      prev_t1 = 1'b0;
    end else begin
      if (sb_on && bus.T1 && !prev_t1) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_underflow: got T1 at pc %h expected none",
                   bus.PC_out);
        end else begin
          mon_e = exp_q.pop_front();
          check("sb_pc", 32'(bus.PC_out), 32'(mon_e.pc));
          check("sb_opcode", 32'(bus.opcode), 32'(mon_e.ir[15:11]));
          check("sb_operand", 32'(bus.Operand), 32'(mon_e.ir[10:0]));
          check("sb_count", 32'(Instr_count), 32'(mon_e.cnt));
        end
      end
      prev_t1 = bus.T1;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    Run    = 1'b0;
    Stall  = 1'b0;
    pcu_t2 = 1'b0;
    exp_q.delete();
    Reset  = 1'b0;
    cyc(2);
    Reset  = 1'b1;
  endtask

  task automatic fill_default();
    for (int i = 0; i < 256; i++) rom[i] = {5'd1, 3'd0, 8'(i)};
  endtask

  function automatic logic [3:0] phases();
    return {bus.T1, bus.T2, bus.T3, bus.T4};
  endfunction

  // Reference walk: follow the program from address 0.
  task automatic walk(input int n, output logic halt,
                      output logic [7:0] halt_pc);
    logic [7:0]  pc;
    logic [15:0] w;
    exp_t        e;
    pc      = 8'h00;
    halt    = 1'b0;
    halt_pc = 8'h00;
    for (int k = 0; k < n; k++) begin
      w = rom[pc];
      if (w[15:11] == 5'h1F) begin
        halt    = 1'b1;
        halt_pc = pc;
        break;
      end
      e.pc  = pc;
      e.ir  = w;
      e.cnt = 16'(k);
      exp_q.push_back(e);
      pc = (w[15:11] == 5'h05) ? w[7:0] : pc + 8'd1;
    end
  endtask

  initial begin
    logic [3:0]  seen;
    logic [3:0]  ph;
    logic [15:0] w;
    logic        exp_halt;
    logic [7:0]  halt_pc;
    logic        done;

    fill_default();
    #1;
    check("rst_async_pc", 32'(bus.PC_out), 0);
    cyc(2);
    check("rst_phase_halt", {phases(), Halted}, 0);
    check("rst_ir", {bus.opcode, bus.Operand}, 0);
    check("rst_count", 32'(Instr_count), 0);
    Reset = 1'b1;

    // Three sequential instructions
    Run = 1'b1;
    for (int c = 0; c < 15; c++) begin
      cyc(1);
      ph = (c % 5 == 0) ? 4'b0000 : 4'b1000 >> (c % 5 - 1);
      check("seq_phase", 32'(phases()), 32'(ph));
      if (c % 5 == 1) check("seq_pc", 32'(bus.PC_out), c / 5);
    end
    cyc(1);
    check("seq_count", 32'(Instr_count), 3);
    check("seq_pc_end", 32'(bus.PC_out), 3);

    // Jump taken in T4
    do_reset();
    rom[0]    = 16'h2840;
    rom[8'h40] = 16'h1234;
    Run = 1'b1;
    cyc(6);
    check("jump_pc", 32'(bus.PC_out), 32'h40);
    cyc(1);
    check("jump_ir", {bus.opcode, bus.Operand}, 32'h1234);

    // PC_Update outside T4 is ignored
    do_reset();
    pcu_t2 = 1'b1;
    Run = 1'b1;
    cyc(6);
    check("jump_t2_pc", 32'(bus.PC_out), 1);
    fill_default();

    // Stall in T2 for 3 cycles, then in T4 for 2
    do_reset();
    Run = 1'b1;
    cyc(3);
    Stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      check("stall_t2", 32'(phases()), 32'b0100);
    end
    Stall = 1'b0;
    cyc(1);
    check("stall_t3", 32'(phases()), 32'b0010);
    check("stall_pc_op", {bus.PC_out, 3'b0, bus.opcode}, 32'h0001);
    cyc(1);
    Stall = 1'b1;
    cyc(2);
    check("stall_t4_hold", {bus.PC_out, phases()}, 32'h001);
    Stall = 1'b0;
    cyc(1);
    check("stall_t4_pc", {bus.PC_out, phases()}, 32'h010);

    // HALT at address 3
    do_reset();
    rom[3] = 16'hF800;
    Run = 1'b1;
    cyc(17);
    check("halt_state", {Halted, bus.PC_out, bus.opcode}, {1'b1, 8'h03, 5'h1F});
    seen = 4'b0;
    repeat (20) begin
      cyc(1);
      seen |= phases();
    end
    check("halt_no_phase", {Halted, seen}, 32'b10000);
    Reset = 1'b0;
    cyc(1);
    check("halt_reset", {Halted, bus.PC_out}, 0);
    Reset = 1'b1;
    fill_default();

    // Jump to 0xFF, wrap to 0, Run dropped in T2
    do_reset();
    rom[0] = 16'h28FF;
    Run = 1'b1;
    cyc(6);
    check("wrap_jump_pc", 32'(bus.PC_out), 32'hFF);
    cyc(2);
    check("drop_t2", 32'(phases()), 32'b0100);
    Run = 1'b0;
    cyc(2);
    check("drop_t4", 32'(phases()), 32'b0001);
    cyc(1);
    check("wrap_pc", {bus.PC_out, phases()}, 0);
    seen = 4'b0;
    repeat (5) begin
      cyc(1);
      seen |= phases();
    end
    check("drop_idle", {seen, bus.opcode, bus.PC_out}, {4'b0, 5'd1, 8'h00});
    fill_default();

    // Asynchronous reset in T3 of the second instruction
    do_reset();
    Run = 1'b1;
    cyc(9);
    check("ar_pre", {phases(), Instr_count}, {4'b0010, 16'd1});
    #2;
    Reset = 1'b0;
    #1;
    check("ar_zero", {phases(), Halted, bus.opcode, bus.PC_out, Instr_count}, 0);
    check("ar_operand", 32'(bus.Operand), 0);
    cyc(1);
    Reset = 1'b1;

    // Random programs with random stalls
    sb_on = 1'b1;
    for (int t = 0; t < 8; t++) begin
      do_reset();
      for (int i = 0; i < 256; i++) begin
        w = 16'($urandom);
        if (w[15:11] == 5'h1F) w[15:11] = 5'h02;
        if ($urandom_range(0, 3) == 0) w[15:11] = 5'h05;
        if ($urandom_range(0, 63) == 0) w[15:11] = 5'h1F;
        rom[i] = w;
      end
      walk(40, exp_halt, halt_pc);
      Run  = 1'b1;
      done = 1'b0;
      for (int c = 0; c < 3000; c++) begin
        cyc(1);
        Stall = ($urandom_range(0, 3) == 0);
        if (exp_q.size() == 0 && (!exp_halt || Halted)) begin
          done = 1'b1;
          break;
        end
      end
      Stall = 1'b0;
      check("rand_done", 32'(done), 1);
      if (exp_halt)
        check("rand_halt", {Halted, bus.PC_out}, {1'b1, halt_pc});
    end
    sb_on = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
